// File: rtl/serial_bit_tx.sv
// serial_bit_tx: frames a DATA_W-bit word onto a single-wire line as
// start bit (0), data LSB first, [even parity], stop bit (1). Each bit is
// held for CLKS_PER_BIT clock cycles.
//
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   tx_data    word to send, captured when tx_valid && tx_ready
//   tx_valid   producer has a word
//   tx_ready   block can accept a word this cycle (registered)
//   tx_serial  serial line, idles high (registered)
//   tx_busy    frame in progress (registered)
//   tx_done    one-cycle pulse in the last cycle of the stop bit (registered)
module serial_bit_tx #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_serial,
   output logic              tx_busy,
   output logic              tx_done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cyc_q, cyc_n;
   logic [BIT_W-1:0]    bit_q, bit_n;
   logic [DATA_W-1:0]   shift_q, shift_n;
   logic                serial_n, ready_n, busy_n, done_n;
   logic                bit_end;
`ifdef SERIAL_TX_PARITY_EN
   logic                parity_q, parity_n;
`endif

   // Last cycle of the current serial bit
   assign bit_end = (cyc_q == CNT_W'(CLKS_PER_BIT - 1));

   // State, counters, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cyc_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
`ifdef SERIAL_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
         tx_serial <= 1'b1;
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_n;
         cyc_q     <= cyc_n;
         bit_q     <= bit_n;
         shift_q   <= shift_n;
`ifdef SERIAL_TX_PARITY_EN
         parity_q  <= parity_n;
`endif
         tx_serial <= serial_n;
         tx_ready  <= ready_n;
         tx_busy   <= busy_n;
         tx_done   <= done_n;
      end
   end

   // Next-state logic; outputs are decoded from the next state so the
   // registered line changes in the same cycle the FSM enters a bit.
   always_comb begin
      state_n  = state;
      cyc_n    = cyc_q;
      bit_n    = bit_q;
      shift_n  = shift_q;
`ifdef SERIAL_TX_PARITY_EN
      parity_n = parity_q;
`endif

      case (state)
         IDLE: begin
            if (tx_valid) begin
               state_n  = START;
               shift_n  = tx_data;
               cyc_n    = '0;
               bit_n    = '0;
`ifdef SERIAL_TX_PARITY_EN
               parity_n = ^tx_data;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               cyc_n   = '0;
               state_n = DATA;
            end else begin
               cyc_n = cyc_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cyc_n   = '0;
               shift_n = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_W - 1)) begin
                  bit_n = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_q + BIT_W'(1);
               end
            end else begin
               cyc_n = cyc_q + CNT_W'(1);
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               cyc_n   = '0;
               state_n = STOP;
            end else begin
               cyc_n = cyc_q + CNT_W'(1);
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               cyc_n   = '0;
               state_n = IDLE;
            end else begin
               cyc_n = cyc_q + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cyc_n   = '0;
            bit_n   = '0;
         end
      endcase

      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = shift_n[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  serial_n = parity_n;
`endif
         default: serial_n = 1'b1;
      endcase

      ready_n = (state_n == IDLE);
      busy_n  = (state_n != IDLE);
      done_n  = (state_n == STOP) && (cyc_n == CNT_W'(CLKS_PER_BIT - 1));
   end

endmodule
